// File: rtl/reservation_station_pkg.sv
// Shared types and widths for the reservation station: entry layout and tag match helper.
package rs_pkg;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;
  localparam int OP_W   = 6;

  localparam logic [TAG_W-1:0] TAG_NONE = '0;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  tag1;
    logic [DATA_W-1:0] val1;
    logic [TAG_W-1:0]  tag2;
    logic [DATA_W-1:0] val2;
    logic [TAG_W-1:0]  target;
  } rs_entry_t;

  // A broadcast of tag 0 carries no producer and must never wake anything.
  function automatic logic tag_hit(logic cv, logic [TAG_W-1:0] ct, logic [TAG_W-1:0] t);
    return cv && (ct != TAG_NONE) && (ct == t);
  endfunction
endpackage

// File: rtl/reservation_station_if.sv
// Dispatch, writeback broadcast and issue signals between ID/CDB/EU (master) and the station (slave).
interface reservation_station_if;
  import rs_pkg::*;
  logic              in_valid;
  logic [OP_W-1:0]   in_op;
  logic [TAG_W-1:0]  in_tag1, in_tag2;
  logic [DATA_W-1:0] in_val1, in_val2;
  logic [TAG_W-1:0]  in_target;
  logic              full;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              issue_valid;
  logic              issue_ready;
  logic [OP_W-1:0]   issue_op;
  logic [DATA_W-1:0] issue_a, issue_b;
  logic [TAG_W-1:0]  issue_target;

  modport master (
    output in_valid, in_op, in_tag1, in_tag2, in_val1, in_val2, in_target,
    output cdb_valid, cdb_tag, cdb_data, issue_ready,
    input  full, issue_valid, issue_op, issue_a, issue_b, issue_target
  );

  modport slave (
    input  in_valid, in_op, in_tag1, in_tag2, in_val1, in_val2, in_target,
    input  cdb_valid, cdb_tag, cdb_data, issue_ready,
    output full, issue_valid, issue_op, issue_a, issue_b, issue_target
  );
endinterface

// File: rtl/reservation_station_oldest_select.sv
// Oldest-ready picker: grants the ready entry that no other ready entry is older than.
module rs_oldest_select #(
  parameter int N = 4
) (
  input  logic [N-1:0]        ready_i,
  input  logic [N-1:0][N-1:0] older_i,
  output logic [N-1:0]        grant_o,
  output logic                any_ready_o
);
  // older_i[j][i]=1 means entry j was dispatched before entry i.
  always_comb begin
    grant_o = '0;
    for (int i = 0; i < N; i++) begin
      grant_o[i] = ready_i[i];
      for (int j = 0; j < N; j++)
        if (j != i && ready_i[j] && older_i[j][i]) grant_o[i] = 1'b0;
    end
  end

  assign any_ready_o = |ready_i;
endmodule

// File: rtl/reservation_station.sv
// Reservation station: holds dispatched ops until operands arrive on the CDB, issues oldest ready first.
module reservation_station #(
  parameter int ENTRY_NUM = 4,
  parameter int TAG_W     = rs_pkg::TAG_W,
  parameter int DATA_W    = rs_pkg::DATA_W,
  parameter int OP_W      = rs_pkg::OP_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  reservation_station_if.slave  bus
);
  import rs_pkg::*;

  localparam int IDX_W = $clog2(ENTRY_NUM);

  rs_entry_t [ENTRY_NUM-1:0]            ent_q, ent_d;
  logic [ENTRY_NUM-1:0][ENTRY_NUM-1:0]  age_q, age_d;
  logic [ENTRY_NUM-1:0]                 vld, rdy, gnt;
  logic                                 any_rdy, full, do_issue, do_disp, found;
  logic [IDX_W-1:0]                     free_idx;
  rs_entry_t                            sel, new_ent;
  logic [TAG_W-1:0]                     cdb_tag_w;
  logic [DATA_W-1:0]                    cdb_data_w;
  logic [OP_W-1:0]                      in_op_w;

  assign cdb_tag_w  = bus.cdb_tag;
  assign cdb_data_w = bus.cdb_data;
  assign in_op_w    = bus.in_op;

  always_comb begin
    vld = '0;
    rdy = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      vld[i] = ent_q[i].valid;
      rdy[i] = ent_q[i].valid && ent_q[i].tag1 == TAG_NONE && ent_q[i].tag2 == TAG_NONE;
    end
  end

  assign full = &vld;

  rs_oldest_select #(.N(ENTRY_NUM)) u_sel (
    .ready_i     (rdy),
    .older_i     (age_q),
    .grant_o     (gnt),
    .any_ready_o (any_rdy)
  );

  // One-hot OR mux; yields all zeros when nothing is granted.
  always_comb begin
    sel = '0;
    for (int i = 0; i < ENTRY_NUM; i++)
      if (gnt[i]) sel = sel | ent_q[i];
  end

  assign bus.full         = full;
  assign bus.issue_valid  = any_rdy;
  assign bus.issue_op     = sel.op;
  assign bus.issue_a      = sel.val1;
  assign bus.issue_b      = sel.val2;
  assign bus.issue_target = sel.target;

  always_comb begin
    new_ent        = '0;
    new_ent.valid  = 1'b1;
    new_ent.op     = in_op_w;
    new_ent.tag1   = bus.in_tag1;
    new_ent.val1   = bus.in_val1;
    new_ent.tag2   = bus.in_tag2;
    new_ent.val2   = bus.in_val2;
    new_ent.target = bus.in_target;
    if (tag_hit(bus.cdb_valid, cdb_tag_w, bus.in_tag1)) begin
      new_ent.tag1 = TAG_NONE;
      new_ent.val1 = cdb_data_w;
    end
    if (tag_hit(bus.cdb_valid, cdb_tag_w, bus.in_tag2)) begin
      new_ent.tag2 = TAG_NONE;
      new_ent.val2 = cdb_data_w;
    end
  end

  always_comb begin
    ent_d    = ent_q;
    age_d    = age_q;
    do_issue = any_rdy && bus.issue_ready;
    do_disp  = bus.in_valid && !full;
    free_idx = '0;
    found    = 1'b0;
    for (int i = 0; i < ENTRY_NUM; i++)
      if (!vld[i] && !found) begin
        free_idx = IDX_W'(i);
        found    = 1'b1;
      end
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (tag_hit(bus.cdb_valid, cdb_tag_w, ent_q[i].tag1)) begin
        ent_d[i].tag1 = TAG_NONE;
        ent_d[i].val1 = cdb_data_w;
      end
      if (tag_hit(bus.cdb_valid, cdb_tag_w, ent_q[i].tag2)) begin
        ent_d[i].tag2 = TAG_NONE;
        ent_d[i].val2 = cdb_data_w;
      end
    end
    if (do_issue)
      for (int i = 0; i < ENTRY_NUM; i++)
        if (gnt[i]) begin
          ent_d[i].valid = 1'b0;
          age_d[i]       = '0;
          for (int j = 0; j < ENTRY_NUM; j++) age_d[j][i] = 1'b0;
        end
    // The free slot was invalid at cycle start, so it is never the one issuing.
    if (do_disp) begin
      ent_d[free_idx] = new_ent;
      age_d[free_idx] = '0;
      for (int j = 0; j < ENTRY_NUM; j++)
        age_d[j][free_idx] = vld[j] && !(do_issue && gnt[j]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ent_q <= '0;
      age_q <= '0;
    end else begin
      ent_q <= ent_d;
      age_q <= age_d;
    end
  end
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for the reservation station: queue-ordered model checked every cycle plus literal spot checks.
module tb_reservation_station;
  logic clk = 1'b0;
  logic rst, flush;
  int   checks = 0, failures = 0;
  logic chk_en = 1'b0;

  reservation_station_if bus();

  reservation_station u_dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [3:0]  t1;
    logic [31:0] v1;
    logic [3:0]  t2;
    logic [31:0] v2;
    logic [3:0]  tgt;
  } m_t;
  m_t mq[$];

  function automatic int m_sel();
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].t1 == 0 && mq[i].t2 == 0) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: entries kept in dispatch order; the first ready one is the issue candidate.
  always @(posedge clk) begin : mdl
    int   s;
    logic fl;
    m_t   e;
    if (rst || flush) mq.delete();
    else begin
      fl = (mq.size() == 4);
      s  = m_sel();
      if (s >= 0 && bus.issue_ready) mq.delete(s);
      if (bus.cdb_valid && bus.cdb_tag != 0)
        for (int i = 0; i < mq.size(); i++) begin
          if (mq[i].t1 == bus.cdb_tag) begin mq[i].t1 = 0; mq[i].v1 = bus.cdb_data; end
          if (mq[i].t2 == bus.cdb_tag) begin mq[i].t2 = 0; mq[i].v2 = bus.cdb_data; end
        end
      if (bus.in_valid && !fl) begin
        e = '{bus.in_op, bus.in_tag1, bus.in_val1, bus.in_tag2, bus.in_val2, bus.in_target};
        if (bus.cdb_valid && bus.cdb_tag != 0 && bus.cdb_tag == e.t1) begin e.t1 = 0; e.v1 = bus.cdb_data; end
        if (bus.cdb_valid && bus.cdb_tag != 0 && bus.cdb_tag == e.t2) begin e.t2 = 0; e.v2 = bus.cdb_data; end
        mq.push_back(e);
      end
    end
  end

  always @(negedge clk) begin : cmp
    int s;
    if (chk_en) begin
      s = m_sel();
      chk("full", 32'(bus.full), 32'(mq.size() == 4));
      chk("issue_valid", 32'(bus.issue_valid), 32'(s >= 0));
      chk("issue_op", 32'(bus.issue_op), s >= 0 ? 32'(mq[s].op) : 32'd0);
      chk("issue_a", bus.issue_a, s >= 0 ? mq[s].v1 : 32'd0);
      chk("issue_b", bus.issue_b, s >= 0 ? mq[s].v2 : 32'd0);
      chk("issue_target", 32'(bus.issue_target), s >= 0 ? 32'(mq[s].tgt) : 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_tag1 = '0; bus.in_tag2 = '0;
    bus.in_val1 = '0; bus.in_val2 = '0; bus.in_target = '0;
    bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.cdb_data = '0;
  endtask

  task automatic disp(input logic [5:0] op, input logic [3:0] t1, input logic [31:0] v1,
                      input logic [3:0] t2, input logic [31:0] v2, input logic [3:0] tgt);
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_tag1 = t1; bus.in_val1 = v1;
    bus.in_tag2 = t2; bus.in_val2 = v2; bus.in_target = tgt;
  endtask

  task automatic cdb(input logic [3:0] t, input logic [31:0] d);
    bus.cdb_valid = 1'b1; bus.cdb_tag = t; bus.cdb_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.issue_ready = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_ivalid", 32'(bus.issue_valid), 32'd0);
    chk("rst_target", 32'(bus.issue_target), 32'd0);

    // Ready-at-dispatch: issued the very next cycle.
    disp(6'd5, 4'd0, 32'd3, 4'd0, 32'd4, 4'd7);
    bus.issue_ready = 1'b1;
    tick(); idle();
    chk("t1_valid", 32'(bus.issue_valid), 32'd1);
    chk("t1_op", 32'(bus.issue_op), 32'd5);
    chk("t1_a", bus.issue_a, 32'd3);
    chk("t1_b", bus.issue_b, 32'd4);
    chk("t1_target", 32'(bus.issue_target), 32'd7);
    tick();
    bus.issue_ready = 1'b0;
    chk("t1_empty", 32'(bus.issue_valid), 32'd0);

    // Wakeup by snoop.
    disp(6'd1, 4'd2, 32'd0, 4'd0, 32'd9, 4'd3);
    tick(); idle(); tick();
    cdb(4'd2, 32'h55);
    chk("t2_wait", 32'(bus.issue_valid), 32'd0);
    tick(); idle();
    chk("t2_valid", 32'(bus.issue_valid), 32'd1);
    chk("t2_a", bus.issue_a, 32'h55);
    chk("t2_b", bus.issue_b, 32'd9);
    bus.issue_ready = 1'b1;
    tick();
    bus.issue_ready = 1'b0;

    // Dispatch-cycle bypass.
    disp(6'd2, 4'd3, 32'd0, 4'd0, 32'd1, 4'd4);
    cdb(4'd3, 32'hAA);
    tick(); idle();
    chk("t3_a", bus.issue_a, 32'hAA);
    bus.issue_ready = 1'b1;
    tick();
    bus.issue_ready = 1'b0;

    // Fill, reject extra dispatch, drain in order.
    for (int k = 0; k < 4; k++) begin
      disp(6'd3, 4'd1, 32'd0, 4'd0, 32'(k), 4'(10 + k));
      tick();
    end
    idle();
    chk("t4_full", 32'(bus.full), 32'd1);
    disp(6'd4, 4'd0, 32'd0, 4'd0, 32'd0, 4'd9);
    tick(); idle();
    cdb(4'd1, 32'h11);
    tick(); idle();
    for (int k = 0; k < 4; k++) begin
      chk("t4_order", 32'(bus.issue_target), 32'(10 + k));
      bus.issue_ready = 1'b1;
      tick();
      bus.issue_ready = 1'b0;
      tick();
    end
    chk("t4_drained", 32'(bus.issue_valid), 32'd0);
    chk("t4_notfull", 32'(bus.full), 32'd0);

    // Younger ready bypasses older waiting; then age order among ready.
    disp(6'd6, 4'd4, 32'd0, 4'd0, 32'd0, 4'd5);
    tick();
    disp(6'd7, 4'd0, 32'd1, 4'd0, 32'd2, 4'd6);
    tick(); idle();
    chk("t5_young", 32'(bus.issue_target), 32'd6);
    bus.issue_ready = 1'b1;
    tick();
    bus.issue_ready = 1'b0;
    chk("t5_gap", 32'(bus.issue_valid), 32'd0);
    cdb(4'd4, 32'h44);
    tick(); idle();
    chk("t5_old", 32'(bus.issue_target), 32'd5);
    bus.issue_ready = 1'b1;
    tick();
    bus.issue_ready = 1'b0;
    disp(6'd8, 4'd0, 32'd0, 4'd0, 32'd0, 4'd7);
    tick();
    disp(6'd9, 4'd0, 32'd0, 4'd0, 32'd0, 4'd8);
    tick(); idle();
    chk("t5_c", 32'(bus.issue_target), 32'd7);
    bus.issue_ready = 1'b1;
    tick();
    chk("t5_d", 32'(bus.issue_target), 32'd8);
    tick();
    bus.issue_ready = 1'b0;

    // Flush, then reset, each with a concurrent dispatch.
    for (int r = 0; r < 2; r++) begin
      disp(6'd10, 4'd5, 32'd0, 4'd0, 32'd0, 4'd1);
      tick();
      disp(6'd11, 4'd5, 32'd0, 4'd0, 32'd0, 4'd2);
      tick();
      disp(6'd12, 4'd0, 32'd0, 4'd0, 32'd0, 4'd3);
      if (r == 0) flush = 1'b1; else rst = 1'b1;
      tick(); idle();
      chk("t6_full", 32'(bus.full), 32'd0);
      chk("t6_valid", 32'(bus.issue_valid), 32'd0);
      cdb(4'd5, 32'h5);
      tick(); idle();
      tick();
      chk("t6_gone", 32'(bus.issue_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Receiving end of the decode-to-execute dispatch interface.
- Accepts decoded instructions (op, two operand tag/value pairs, ROB destination tag) from the ID stage.
- Holds each instruction until both operands are ready, capturing operand values by snooping the writeback broadcast bus.
- Issues the oldest ready instruction to its execution unit. Drives the per-unit `full` flag that ID uses to stall fetch.

Parameters:
- ENTRY_NUM, 4, number of station entries (≥2).
- TAG_W, 4, ROB tag width. Tag 0 means "no producer / value valid".
- DATA_W, 32, operand width.
- OP_W, 6, internal opcode width.

Ports:
- clk  in  1  clock (the block's only clock).
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of all entries (branch recovery).
- in_valid  in  1  dispatch request from ID for this unit.
- in_op  in  OP_W  opcode.
- in_tag1, in_tag2  in  TAG_W  operand producer tags (0 = value already valid).
- in_val1, in_val2  in  DATA_W  operand values (meaningful only when the matching tag is 0).
- in_target  in  TAG_W  ROB destination tag.
- full  out  1  all entries occupied.
- cdb_valid  in  1  writeback broadcast valid.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_data  in  DATA_W  broadcast value.
- issue_valid  out  1  an instruction is offered to the execution unit.
- issue_ready  in  1  execution unit accepts this cycle.
- issue_op  out  OP_W  issued opcode.
- issue_a, issue_b  out  DATA_W  operand values.
- issue_target  out  TAG_W  ROB tag of the issued instruction.

Behaviour:
- Entry state: valid, op, tag1, val1, tag2, val2, target. Ordering is kept in an ENTRY_NUM x ENTRY_NUM age matrix.
- Reset (rst=1 at a clk edge): all valid bits and the age matrix clear. Outputs after reset: full=0, issue_valid=0, issue_op/a/b/target=0. Reset mid-operation discards every held instruction, with no partial issue.
- flush: same effect as reset on entries. flush takes priority over dispatch and snoop in the same cycle.
- full: combinational from registered valid bits. It is 1 iff all ENTRY_NUM entries are valid. Freeing an entry by issue lowers full only from the next cycle.
- Dispatch:
  - When in_valid=1 and full=0, write the instruction into the lowest-index entry that is invalid at the start of the cycle. It becomes visible next cycle.
  - Set older[j][k]=1 for every currently valid entry j (and clear older[k][*]).
  - in_valid=1 while full=1 is ignored. State is not modified; ID is responsible for stalling.
- Dispatch bypass: if cdb_valid=1 and cdb_tag≠0 and cdb_tag equals in_tagN in the dispatch cycle, store cdb_data as valN and tagN=0.
- Snoop: each valid entry with tagN≠0 and tagN==cdb_tag while cdb_valid=1 stores cdb_data into valN and clears tagN at the edge. Both operands may match the same broadcast. cdb_tag=0 never matches.
- Ready: entry valid with tag1==0 and tag2==0, using registered state. Wakeup-to-issue latency is therefore 1 cycle after the broadcast edge; there is no same-cycle broadcast-to-issue forwarding.
- Select: among ready entries, choose the one with no older ready entry.
  - issue_valid and issue_* are combinational from the selected entry.
  - issue_* are driven to 0 when issue_valid=0.
- Issue handshake:
  - On issue_valid && issue_ready, the selected entry is invalidated at the edge and its age-matrix row and column are cleared.
  - If issue_ready=0, the offer holds. A newly ready older entry may replace the offered one; the execution unit must not assume stability without acceptance.
- Simultaneous events: dispatch, snoop and issue in one cycle are all honoured. Dispatch never targets the entry being issued that cycle. A snoop to the entry being issued is harmless.
- Single instruction minimum latency: dispatch at edge N with ready operands gives issue_valid=1 in cycle N+1.

Decomposition:
- Package rs_pkg:
  - TAG_W, DATA_W, OP_W defaults.
  - TAG_NONE = 0.
  - rs_entry_t packed struct {valid, op, tag1, val1, tag2, val2, target}.
- Sub-module rs_oldest_select: purely combinational. Inputs are the ready vector and the age matrix. Outputs are a one-hot grant and any_ready.

Test Plan:
- Reset, then in_valid=1, op=5, tag1=tag2=0, val1=3, val2=4, target=7 -> next cycle issue_valid=1, issue_a=3, issue_b=4, issue_target=7. With issue_ready=1 the station is empty the following cycle.
- Dispatch tag1=2, val2=9 (tag2=0). Two cycles later cdb_valid=1, cdb_tag=2, cdb_data=0x55 -> issue_valid=0 until the cycle after the broadcast, then issue_a=0x55, issue_b=9.
- Dispatch with in_tag1=3 in the same cycle as cdb_tag=3, cdb_data=0xAA -> entry ready next cycle with issue_a=0xAA.
- Fill 4 entries with unresolved tag 1, hold issue_ready=0 -> full=1, and an extra dispatch (target=9) never appears. Broadcast tag 1 -> targets are issued in dispatch order as issue_ready pulses.
- Entries A (older, tag1=4) and B (ready) -> B issues first. After tag 4 broadcast, A issues. Both ready simultaneously -> older issues first.
- Entries pending, assert flush (or rst) for one cycle with a concurrent dispatch -> full=0, issue_valid=0, and the dispatched instruction is not retained.
